// File: rtl/mod53_residue_accumulator.sv
// Accumulates per-chunk mod-MODULUS partial residues over a valid/ready stream and
// emits one reduced residue per packet, with beat count and force-termination flag.
module mod53_residue_accumulator #(
    parameter int MODULUS    = 53,
    parameter int WIDTH      = 6,
    parameter int MAX_CHUNKS = 8,
    localparam int CNT_W     = $clog2(MAX_CHUNKS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_residue,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    localparam logic [WIDTH:0] MOD_X    = (WIDTH + 1)'(MODULUS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_CHUNKS - 1);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] sum;
    logic             accept;
    logic             terminate;

    // Single conditional subtract; valid because every input is below 2*MODULUS.
    function automatic logic [WIDTH-1:0] mod_reduce(input logic [WIDTH:0] x);
        logic [WIDTH:0] d;
        d = x - MOD_X;
        return (x >= MOD_X) ? d[WIDTH-1:0] : x[WIDTH-1:0];
    endfunction

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);

    assign accept    = in_valid & in_ready;
    assign r         = mod_reduce({1'b0, in_data});
    assign s         = {1'b0, acc} + {1'b0, r};
    assign sum       = mod_reduce(s);
    assign terminate = accept & (in_last | (cnt == LAST_IDX));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (terminate) state_d = DONE;
            DONE:    if (out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
        if (sclr) state_d = ACC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            out_residue <= '0;
            out_count   <= '0;
            out_err     <= 1'b0;
        end else if (sclr) begin
            acc     <= '0;
            cnt     <= '0;
            out_err <= 1'b0;
        end else if (accept) begin
            if (terminate) begin
                out_residue <= sum;
                out_count   <= cnt + CNT_W'(1);
                out_err     <= ~in_last;
                acc         <= '0;
                cnt         <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mod53_residue_accumulator.sv
// Directed bench for mod53_residue_accumulator with hand-computed expected results.
module tb_mod53_residue_accumulator;

    localparam int WIDTH = 6;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sclr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_residue;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    int checks = 0;
    int errors = 0;

    mod53_residue_accumulator #(
        .MODULUS   (53),
        .WIDTH     (WIDTH),
        .MAX_CHUNKS(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclr       (sclr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_residue(out_residue),
        .out_count  (out_count),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat, waits (bounded) for in_ready, then clocks it in.
    task automatic send_beat(input int data, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = WIDTH'(data);
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("beat_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int res, input int cnt, input int err);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_residue"}, int'(out_residue), res);
        check({tag, "_count"}, int'(out_count), cnt);
        check({tag, "_err"}, int'(out_err), err);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, int'(out_valid), 0);
        check({tag, "_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        #22;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_residue", int'(out_residue), 0);
        check("rst_count", int'(out_count), 0);
        check("rst_err", int'(out_err), 0);
        rst_n = 1'b1;
        tick();

        // Single beat: valid must not rise before the accepting edge
        in_valid = 1'b1; in_data = 6'd52; in_last = 1'b1;
        check("t1_pre_valid", int'(out_valid), 0);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check_result("t1", 52, 1, 0);
        consume("t1");

        send_beat(40, 1'b0);
        send_beat(30, 1'b0);
        send_beat(20, 1'b1);
        check_result("t2", 37, 3, 0);
        consume("t2");

        send_beat(63, 1'b0);
        send_beat(60, 1'b1);
        check_result("t3", 17, 2, 0);
        consume("t3");

        // Backpressure: pending result held, input stalled
        send_beat(7, 1'b1);
        in_valid = 1'b1; in_data = 6'd9; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_in_ready", int'(in_ready), 0);
            check("t4_valid", int'(out_valid), 1);
            check("t4_residue", int'(out_residue), 7);
            check("t4_count", int'(out_count), 1);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        check("t4_ready_back", int'(in_ready), 1);
        check("t4_drop_valid", int'(out_valid), 0);
        send_beat(5, 1'b1);
        check_result("t4_next", 5, 1, 0);
        consume("t4");

        // Overlong packet is force-terminated after beat 8
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(1, 1'b0);
        check_result("t5", 8, 8, 1);
        send_beat(1, 1'b0);
        out_ready = 1'b0;
        send_beat(2, 1'b1);
        check_result("t5_next", 3, 2, 0);
        consume("t5");

        // Asynchronous reset mid-packet
        send_beat(10, 1'b0);
        send_beat(20, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", int'(out_valid), 0);
        check("t6_rst_residue", int'(out_residue), 0);
        check("t6_rst_count", int'(out_count), 0);
        check("t6_rst_err", int'(out_err), 0);
        check("t6_rst_ready", int'(in_ready), 1);
        #3 rst_n = 1'b1;
        tick();
        send_beat(5, 1'b1);
        check_result("t6_rst_next", 5, 1, 0);
        consume("t6_rst");

        // Synchronous clear mid-packet drops the concurrent beat
        send_beat(10, 1'b0);
        send_beat(20, 1'b0);
        sclr = 1'b1; in_valid = 1'b1; in_data = 6'd7; in_last = 1'b1;
        tick();
        sclr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("t6_sclr_valid", int'(out_valid), 0);
        check("t6_sclr_err", int'(out_err), 0);
        check("t6_sclr_ready", int'(in_ready), 1);
        send_beat(5, 1'b1);
        check_result("t6_sclr_next", 5, 1, 0);
        consume("t6_sclr");

        // Clear while a forced-error result is pending
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(2, 1'b0);
        check_result("t7", 16, 8, 1);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check("t7_sclr_valid", int'(out_valid), 0);
        check("t7_sclr_err", int'(out_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
